// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared constants and types for the FIFO pointer/flag
// controller and its round-robin write arbiter.
//   FIFO_DEPTH_DEF : default number of FIFO entries
//   ptr_width()    : pointer/count width (address bits plus wrap bit)
//   prod_idx_t     : producer index (two producers)
//   LAST_GNT_RST   : last_gnt reset value, so producer 0 wins the first tie
package fifo_ctrl_pkg;

    localparam int FIFO_DEPTH_DEF = 8;

    // Pointers and the occupancy count carry one extra bit so that a full
    // FIFO (DEPTH entries) is distinguishable from an empty one.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic prod_idx_t;

    localparam prod_idx_t LAST_GNT_RST = 1'b1;

endpackage

// File: rtl/fifo_ctrl_arb_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter, purely combinational.
//   req      in  [1:0] request per producer
//   enable   in        arbitration allowed (low forces no grant)
//   last_gnt in        producer granted most recently (register lives in parent)
//   gnt      out [1:0] one-hot grant, zero when nothing is granted
module rr_arb2
    import fifo_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       enable,
    input  prod_idx_t  last_gnt,
    output logic [1:0] gnt
);

    // Grant the lone requester; on a tie grant the one not served last.
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_gnt == 1'b1) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/fifo_ctrl_arb.sv
// fifo_ctrl_arb: pointer/flag controller and two-writer round-robin arbiter
// for an external FIFO storage array. Carries no data.
//   clk, reset            : clock; synchronous active-high reset
//   wr_req[1:0]           : per-producer write request
//   wr_gnt[1:0], wr_en    : one-hot grant and array write strobe (combinational)
//   wr_sel                : granted producer index for the data mux
//   wr_addr, rd_addr      : array write/read addresses
//   rd_req, rd_en         : consumer request and acceptance (combinational)
//   full, empty, count    : registered occupancy state
//   almost_full           : count >= AFULL_TH, present only when the macro
//                           FIFO_CTRL_AFULL_EN is defined
module fifo_ctrl_arb
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
`ifdef FIFO_CTRL_AFULL_EN
    parameter int AFULL_TH = DEPTH - 2,
`endif
    localparam int AW = $clog2(DEPTH)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    wr_req,
    output logic [1:0]    wr_gnt,
    output logic          wr_en,
    output logic          wr_sel,
    output logic [AW-1:0] wr_addr,
    input  logic          rd_req,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
`ifdef FIFO_CTRL_AFULL_EN
    ,
    output logic          almost_full
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] count_r;
    logic          full_r;
    logic          empty_r;
    prod_idx_t     last_gnt_r;

    logic [1:0]    gnt_s;
    logic          arb_en_s;
    logic          wr_en_s;
    logic          rd_en_s;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [PW-1:0] count_nxt_s;

    // A full FIFO refuses writes even if a read frees a slot this cycle.
    assign arb_en_s = ~full_r;

    rr_arb2 u_arb (
        .req      (wr_req),
        .enable   (arb_en_s),
        .last_gnt (last_gnt_r),
        .gnt      (gnt_s)
    );

    assign wr_en_s = |gnt_s;
    assign rd_en_s = rd_req & ~empty_r;

    assign wr_gnt  = gnt_s;
    assign wr_en   = wr_en_s;
    assign wr_sel  = gnt_s[1];
    assign rd_en   = rd_en_s;
    assign wr_addr = wr_ptr_r[AW-1:0];
    assign rd_addr = rd_ptr_r[AW-1:0];
    assign full    = full_r;
    assign empty   = empty_r;
    assign count   = count_r;

    // Next pointer and occupancy values for the accepted transfers.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (wr_en_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (rd_en_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_nxt_s = count_r + PTR_ONE;
            2'b01:   count_nxt_s = count_r - PTR_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, occupancy and flag registers; flags derive from next pointers
    // so they always agree with the pointers they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {PW{1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            last_gnt_r <= LAST_GNT_RST;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]) &&
                        (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]);
            empty_r  <= (wr_ptr_nxt_s == rd_ptr_nxt_s);
            if (wr_en_s) begin
                last_gnt_r <= prod_idx_t'(gnt_s[1]);
            end else begin
                last_gnt_r <= last_gnt_r;
            end
        end
    end

`ifdef FIFO_CTRL_AFULL_EN
    localparam logic [PW-1:0] AFULL_C = PW'(AFULL_TH);

    logic almost_full_r;

    assign almost_full = almost_full_r;

    // Almost-full tracks the count register, judged on the next count.
    always_ff @(posedge clk) begin
        if (reset) begin
            almost_full_r <= 1'b0;
        end else begin
            almost_full_r <= (count_nxt_s >= AFULL_C);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ctrl_arb.sv
// Self-checking bench for fifo_ctrl_arb (DEPTH = 8): a directed vector table,
// hand-written reset and wrap sequences, and randomized traffic checked
// against a queue-based reference model with an emulated storage array.
module tb_fifo_ctrl_arb;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef FIFO_CTRL_AFULL_EN
    localparam int AFULL_TH = DEPTH - 2;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    wr_req = 2'b00;
    logic          rd_req = 1'b0;
    logic [1:0]    wr_gnt;
    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
`ifdef FIFO_CTRL_AFULL_EN
    logic          almost_full;
`endif

    int checks = 0;
    int errors = 0;

    fifo_ctrl_arb dut (
        .clk     (clk),
        .reset   (reset),
        .wr_req  (wr_req),
        .wr_gnt  (wr_gnt),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .rd_req  (rd_req),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .full    (full),
        .empty   (empty),
        .count   (count)
`ifdef FIFO_CTRL_AFULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1; wr_req = 2'b00; rd_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0] wr;
        logic       rd;
        logic [1:0] gnt;
        logic       rden;
        int         cnt;
        int         wa;
        int         ra;
        logic       e;
        logic       f;
    } vec_t;

    vec_t tbl[15];

    // reference model state
    int q[$];
    int mem[DEPTH];
    int last_w;
    int wr_tot;
    int rd_tot;
    int token;

    initial begin
        // Expected values describe the cycle before the edge commits it.
        tbl[0]  = '{2'b00, 1'b1, 2'b00, 1'b0, 0, 0, 0, 1'b1, 1'b0};
        tbl[1]  = '{2'b11, 1'b0, 2'b01, 1'b0, 0, 0, 0, 1'b1, 1'b0};
        tbl[2]  = '{2'b11, 1'b0, 2'b10, 1'b0, 1, 1, 0, 1'b0, 1'b0};
        tbl[3]  = '{2'b11, 1'b0, 2'b01, 1'b0, 2, 2, 0, 1'b0, 1'b0};
        tbl[4]  = '{2'b11, 1'b0, 2'b10, 1'b0, 3, 3, 0, 1'b0, 1'b0};
        tbl[5]  = '{2'b11, 1'b0, 2'b01, 1'b0, 4, 4, 0, 1'b0, 1'b0};
        tbl[6]  = '{2'b11, 1'b0, 2'b10, 1'b0, 5, 5, 0, 1'b0, 1'b0};
        tbl[7]  = '{2'b01, 1'b0, 2'b01, 1'b0, 6, 6, 0, 1'b0, 1'b0};
        tbl[8]  = '{2'b01, 1'b0, 2'b01, 1'b0, 7, 7, 0, 1'b0, 1'b0};
        tbl[9]  = '{2'b01, 1'b0, 2'b00, 1'b0, 8, 0, 0, 1'b0, 1'b1};
        tbl[10] = '{2'b01, 1'b1, 2'b00, 1'b1, 8, 0, 0, 1'b0, 1'b1};
        tbl[11] = '{2'b01, 1'b0, 2'b01, 1'b0, 7, 0, 1, 1'b0, 1'b0};
        tbl[12] = '{2'b10, 1'b1, 2'b00, 1'b1, 8, 1, 1, 1'b0, 1'b1};
        tbl[13] = '{2'b10, 1'b1, 2'b10, 1'b1, 7, 1, 2, 1'b0, 1'b0};
        tbl[14] = '{2'b00, 1'b1, 2'b00, 1'b1, 7, 2, 3, 1'b0, 1'b0};

        reset_dut();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            wr_req = tbl[i].wr;
            rd_req = tbl[i].rd;
            #1;
            chk($sformatf("row%0d wr_gnt", i), wr_gnt, tbl[i].gnt);
            chk($sformatf("row%0d wr_en", i), wr_en, |tbl[i].gnt);
            chk($sformatf("row%0d wr_sel", i), wr_sel, tbl[i].gnt[1]);
            chk($sformatf("row%0d rd_en", i), rd_en, tbl[i].rden);
            chk($sformatf("row%0d count", i), count, tbl[i].cnt);
            chk($sformatf("row%0d wr_addr", i), wr_addr, tbl[i].wa);
            chk($sformatf("row%0d rd_addr", i), rd_addr, tbl[i].ra);
            chk($sformatf("row%0d empty", i), empty, tbl[i].e);
            chk($sformatf("row%0d full", i), full, tbl[i].f);
        end

        // Mid-operation reset with both producers requesting.
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr_req = 2'b01; rd_req = 1'b0;
        end
        @(negedge clk);
        wr_req = 2'b11; reset = 1'b1;
        #1;
        chk("midrst count_before", count, 5);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst count", count, 0);
        chk("midrst empty", empty, 1'b1);
        chk("midrst full", full, 1'b0);
        chk("midrst wr_addr", wr_addr, 0);
        chk("midrst rd_addr", rd_addr, 0);
        chk("midrst first_tie", wr_gnt, 2'b01);

        // Wrap: alternate one write and one read, twelve times.
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            wr_req = 2'b01; rd_req = 1'b0;
            #1;
            chk($sformatf("wrap%0d wr_addr", i), wr_addr, i % DEPTH);
            @(negedge clk);
            wr_req = 2'b00; rd_req = 1'b1;
            #1;
            chk($sformatf("wrap%0d rd_addr", i), rd_addr, i % DEPTH);
            chk($sformatf("wrap%0d rd_en", i), rd_en, 1'b1);
            chk($sformatf("wrap%0d count", i), count, 1);
        end
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        chk("wrap end empty", empty, 1'b1);
        chk("wrap end count", count, 0);

        // Randomized traffic against the reference model.
        reset_dut();
        q.delete();
        last_w = 1; wr_tot = 0; rd_tot = 0; token = 0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            int pw, pr, win, ph;
            logic exp_rden, do_rst;
            logic [1:0] cand, exp_gnt;
            ph = (cyc / 60) % 3;
            pw = (ph == 0) ? 85 : ((ph == 1) ? 20 : 50);
            pr = (ph == 0) ? 20 : ((ph == 1) ? 85 : 50);
            @(negedge clk);
            do_rst = ($urandom_range(0, 99) < 2);
            reset  = do_rst;
            wr_req[0] = ($urandom_range(0, 99) < pw);
            wr_req[1] = ($urandom_range(0, 99) < pw);
            rd_req    = ($urandom_range(0, 99) < pr);
            #1;
            cand = (q.size() == DEPTH) ? 2'b00 : wr_req;
            if (cand == 2'b11)      win = (last_w == 1) ? 0 : 1;
            else if (cand == 2'b01) win = 0;
            else if (cand == 2'b10) win = 1;
            else                    win = -1;
            exp_gnt  = (win < 0) ? 2'b00 : ((win == 0) ? 2'b01 : 2'b10);
            exp_rden = rd_req && (q.size() > 0);
            chk("rnd wr_gnt", wr_gnt, exp_gnt);
            chk("rnd wr_en", wr_en, win >= 0);
            chk("rnd wr_sel", wr_sel, win == 1);
            chk("rnd rd_en", rd_en, exp_rden);
            chk("rnd count", count, q.size());
            chk("rnd empty", empty, q.size() == 0);
            chk("rnd full", full, q.size() == DEPTH);
            chk("rnd wr_addr", wr_addr, wr_tot % DEPTH);
            chk("rnd rd_addr", rd_addr, rd_tot % DEPTH);
`ifdef FIFO_CTRL_AFULL_EN
            chk("rnd almost_full", almost_full, q.size() >= AFULL_TH);
`endif
            if (do_rst) begin
                q.delete();
                last_w = 1; wr_tot = 0; rd_tot = 0;
            end else begin
                if (exp_rden) begin
                    chk("rnd data", mem[rd_addr], q[0]);
                    void'(q.pop_front());
                    rd_tot++;
                end
                if (win >= 0) begin
                    token++;
                    mem[wr_addr] = token;
                    q.push_back(token);
                    last_w = win;
                    wr_tot++;
                end
            end
        end
        @(negedge clk);
        reset = 1'b0; wr_req = 2'b00; rd_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl_arb.md
# fifo_ctrl_arb

Pointer/flag controller and two-writer round-robin arbiter for the FIFO storage array built from the team's resettable D flip-flop cells. It owns all sequencing of the array: it decides which of two producers writes each cycle, generates write/read addresses and write/read strobes, and tracks occupancy. Storage and data muxing live outside; this block carries no data.

## Interface
- DEPTH, 8, number of entries; power of two, 2..256
- AW, $clog2(DEPTH), address width (derived, not overridden)
- AFULL_TH, DEPTH-2, almost-full threshold; used only when FIFO_CTRL_AFULL_EN is defined
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- wr_req  input  2  write request per producer, bit i = producer i
- wr_gnt  output  2  one-hot grant (combinational), zero when no write occurs
- wr_en  output  1  array write strobe, equals |wr_gnt
- wr_sel  output  1  index of granted producer (data mux select); 0 when wr_en=0
- wr_addr  output  AW  array write address
- rd_req  input  1  consumer read request
- rd_en  output  1  read accepted this cycle, rd_req & ~empty
- rd_addr  output  AW  array read address; array output at rd_addr is the head word
- full  output  1  occupancy == DEPTH
- empty  output  1  occupancy == 0
- count  output  AW+1  occupancy, 0..DEPTH
- almost_full  output  1  count >= AFULL_TH (only with FIFO_CTRL_AFULL_EN)

## Operation
- Write and read pointers are AW+1 bits; low AW bits drive wr_addr/rd_addr, MSB is the wrap bit. empty = pointers equal; full = low bits equal, MSBs differ.
- Arbitration: candidates = wr_req when ~full, else none. One requester -> grant it. Both -> grant the one not granted last. Register last_gnt updates only when wr_en=1.
- Write: wr_en=1 -> wr_ptr increments on the edge; array captures granted producer's data at wr_addr on the same edge.
- Read: rd_en=1 -> rd_ptr increments on the edge; consumer samples head word in the cycle rd_en is high.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- Flags use current-cycle state only: when full, writes are refused even if rd_en=1 in the same cycle; when empty, rd_req is ignored (no bypass).
- Simultaneous read and write when neither full nor empty: both occur, count unchanged.
- Pointer wrap: DEPTH-1 -> 0 on low bits, MSB toggles; no special handling otherwise.
- Ungranted requester holds wr_req; no internal queuing of requests.

## Timing
- Reset (synchronous, checked at clk edge): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, last_gnt=1 (producer 0 wins first tie). wr_gnt/wr_en/rd_en follow from reset state (rd_en=0, wr_en follows wr_req). Reset asserted mid-traffic discards all contents; any grant in that cycle is not committed.
- Grant, wr_en, rd_en: combinational, zero latency from wr_req/rd_req.
- Flags/count/addresses: registered, updated one edge after the accepted transfer.
- Write-to-read latency: word written at edge N is readable (empty=0) in cycle after N.

## Configuration
- FIFO_CTRL_AFULL_EN defined: almost_full port and AFULL_TH parameter exist; almost_full registered together with count, asserted when next count >= AFULL_TH.
- Not defined: no almost_full port, no threshold logic; AFULL_TH unused.

## Structure
- Package fifo_ctrl_pkg: DEPTH default, pointer/count width helper constants, producer-index type (1-bit), reset value of last_gnt.
- Sub-module rr_arb2: 2-input round-robin arbiter (req, enable, last_gnt in; one-hot gnt out); instantiated once, last_gnt register kept in the parent.

## Test plan
- Reset then idle: after reset, empty=1, full=0, count=0, wr_addr=0, rd_addr=0, rd_req=1 gives rd_en=0.
- Single producer fill: wr_req=01 for 8 cycles, DEPTH=8 -> wr_addr 0..7, count reaches 8, full=1; 9th cycle wr_gnt=00.
- Fairness: wr_req=11 for 6 cycles from reset -> grants 01,10,01,10,01,10; wr_sel 0,1,0,1,0,1.
- Full with read: full, wr_req=01, rd_req=1 -> rd_en=1, wr_gnt=00, count 8->7; next cycle write granted.
- Wrap: 12 writes interleaved with 12 reads -> addresses wrap 7->0, count stays ≤8, empty=1 at end, no data loss.
- Mid-operation reset: count=5, assert reset one cycle with wr_req=11 -> next cycle count=0, empty=1, pointers 0, first tie grants producer 0.
